// File: rtl/mem_stage_lsu.sv
// RV32I memory-access stage: load/store unit between EX/MEM and MEM/WB.
// Drives a req/ready + rvalid data-memory port and stalls upstream until done.
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       rs2_data_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        wb_sel_in,
  input  logic [2:0]        funct3_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       pc_out,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       load_data_out,
  output logic [4:0]        rd_addr_out,
  output logic              reg_write_out,
  output logic [1:0]        wb_sel_out,
  output logic              valid_out,
  output logic              misalign_exc
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state_q, state_d;

  logic              mem_op;
  logic              legal;
  logic              aligned;
  logic              start;
  logic              bad;
  logic [1:0]        off;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [7:0]        lbyte;
  logic [15:0]       lhalf;
  logic [31:0]       ldata_d;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              flush_pend_q;
  logic [31:0]       ldata_q;
  logic              keep;

  assign mem_op = mem_read_in | mem_write_in;
  assign off    = alu_result_in[1:0];

  // Read wins when both read and write are flagged.
  always_comb begin
    legal = 1'b0;
    if (mem_read_in)
      legal = (funct3_in != 3'b011) &&
              (funct3_in != 3'b110) &&
              (funct3_in != 3'b111);
    else
      legal = !funct3_in[2] && (funct3_in[1:0] != 2'b11);
  end

  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      funct3_in[1:0] == 2'b01: aligned = !off[0];
      funct3_in[1:0] == 2'b10: aligned = (off == 2'b00);
      default:                 aligned = 1'b1;
    endcase
  end

  assign start = (state_q == IDLE) && mem_op && !flush && legal && aligned;
  assign bad   = (state_q == IDLE) && mem_op && !flush && !(legal && aligned);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = rs2_data_in;
    unique case (1'b1)
      funct3_in[1:0] == 2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{rs2_data_in[7:0]}};
      end
      funct3_in[1:0] == 2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{rs2_data_in[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = rs2_data_in;
      end
    endcase
  end

  always_comb begin
    lbyte = dmem_rdata[7:0];
    unique case (off_q)
      2'd0:    lbyte = dmem_rdata[7:0];
      2'd1:    lbyte = dmem_rdata[15:8];
      2'd2:    lbyte = dmem_rdata[23:16];
      default: lbyte = dmem_rdata[31:24];
    endcase
  end

  assign lhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ldata_d = dmem_rdata;
    unique case (f3_q)
      3'b000:  ldata_d = {{24{lbyte[7]}}, lbyte};
      3'b001:  ldata_d = {{16{lhalf[15]}}, lhalf};
      3'b100:  ldata_d = {24'b0, lbyte};
      3'b101:  ldata_d = {16'b0, lhalf};
      default: ldata_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (dmem_ready) state_d = we_q ? DONE : RESP;
      RESP:    if (dmem_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = (state_q == REQ);
    stall_out = start || (state_q == REQ) || (state_q == RESP);
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      ldata_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= {alu_result_in[ADDR_W-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
        we_q    <= !mem_read_in;
        f3_q    <= funct3_in;
        off_q   <= off;
        ldata_q <= '0;
      end
      if (state_q == RESP && dmem_rvalid)
        ldata_q <= ldata_d;
      // A flush mid-access lets the access finish but retires it as a bubble.
      if ((state_q == REQ || state_q == RESP) && flush)
        flush_pend_q <= 1'b1;
      else if (state_q == IDLE || state_q == DONE)
        flush_pend_q <= 1'b0;
    end
  end

  assign keep = !(flush || flush_pend_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out         <= '0;
      alu_result_out <= '0;
      load_data_out  <= '0;
      rd_addr_out    <= '0;
      reg_write_out  <= 1'b0;
      wb_sel_out     <= '0;
      valid_out      <= 1'b0;
      misalign_exc   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_out         <= pc_in;
          alu_result_out <= alu_result_in;
          load_data_out  <= '0;
          rd_addr_out    <= rd_addr_in;
          wb_sel_out     <= wb_sel_in;
          valid_out      <= !flush && !start;
          reg_write_out  <= reg_write_in && !flush && !start && !bad;
          misalign_exc   <= bad;
        end
        DONE: begin
          pc_out         <= pc_in;
          alu_result_out <= alu_result_in;
          load_data_out  <= ldata_q;
          rd_addr_out    <= rd_addr_in;
          wb_sel_out     <= wb_sel_in;
          valid_out      <= keep;
          reg_write_out  <= reg_write_in && keep;
          misalign_exc   <= 1'b0;
        end
        default: begin
          valid_out     <= 1'b0;
          reg_write_out <= 1'b0;
          misalign_exc  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu.
// Hand-computed vectors for ALU pass-through, stores, loads, faults, flush, reset.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] pc_in;
  logic [31:0] alu_result_in;
  logic [31:0] rs2_data_in;
  logic [4:0]  rd_addr_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  funct3_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] pc_out;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out;
  logic [1:0]  wb_sel_out;
  logic        valid_out;
  logic        misalign_exc;

  int n_chk = 0;
  int n_err = 0;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .pc_in(pc_in), .alu_result_in(alu_result_in),
    .rs2_data_in(rs2_data_in), .rd_addr_in(rd_addr_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .wb_sel_in(wb_sel_in),
    .funct3_in(funct3_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .alu_result_out(alu_result_out),
    .load_data_out(load_data_out), .rd_addr_out(rd_addr_out),
    .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
    .valid_out(valid_out), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input logic rw,
                        input logic rd_en, input logic wr_en,
                        input logic [2:0] f3);
    pc_in         = 32'h1000 + a;
    alu_result_in = a;
    rs2_data_in   = d;
    rd_addr_in    = rd;
    reg_write_in  = rw;
    mem_read_in   = rd_en;
    mem_write_in  = wr_en;
    wb_sel_in     = 2'd1;
    funct3_in     = f3;
  endtask

  task automatic nop;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    reg_write_in = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input logic [3:0] be,
                          input logic [31:0] wd);
    set_op(a, d, 5'd0, 1'b0, 1'b0, 1'b1, f3);
    dmem_ready = 1'b1;
    #1;
    check("st_stall_idle", 32'(stall_out), 1);
    check("st_req_idle", 32'(dmem_req), 0);
    tick;
    check("st_req", 32'(dmem_req), 1);
    check("st_we", 32'(dmem_we), 1);
    check("st_addr", dmem_addr, a & 32'hFFFF_FFFC);
    check("st_be", 32'(dmem_be), 32'(be));
    check("st_wdata", dmem_wdata, wd);
    check("st_stall_req", 32'(stall_out), 1);
    check("st_bubble", 32'(valid_out), 0);
    tick;
    check("st_stall_done", 32'(stall_out), 0);
    check("st_req_done", 32'(dmem_req), 0);
    tick;
    nop;
    dmem_ready = 1'b0;
    check("st_valid", 32'(valid_out), 1);
    check("st_alu", alu_result_out, a);
    check("st_rw", 32'(reg_write_out), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    #12;
    check("rst_valid", 32'(valid_out), 0);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_stall", 32'(stall_out), 0);
    check("rst_alu", alu_result_out, 0);
    check("rst_exc", 32'(misalign_exc), 0);
    rst_n = 1'b1;

    set_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    check("alu_stall", 32'(stall_out), 0);
    tick;
    check("alu_res", alu_result_out, 32'h1234);
    check("alu_rd", 32'(rd_addr_out), 5);
    check("alu_valid", 32'(valid_out), 1);
    check("alu_rw", 32'(reg_write_out), 1);
    check("alu_pc", pc_out, 32'h2234);
    check("alu_stall2", 32'(stall_out), 0);

    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("fl_idle_valid", 32'(valid_out), 0);
    check("fl_idle_rw", 32'(reg_write_out), 0);

    do_store(32'h103, 32'h0000_00AB, 3'b000, 4'b1000, 32'hABAB_ABAB);
    do_store(32'h102, 32'h1234_CDEF, 3'b001, 4'b1100, 32'hCDEF_CDEF);
    do_store(32'h200, 32'hDEAD_BEEF, 3'b010, 4'b1111, 32'hDEAD_BEEF);

    set_op(32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    dmem_ready = 1'b0;
    #1;
    check("lb_stall_idle", 32'(stall_out), 1);
    tick;
    for (int i = 0; i < 3; i++) begin
      check("lb_wait_req", 32'(dmem_req), 1);
      check("lb_wait_addr", dmem_addr, 32'h100);
      check("lb_wait_be", 32'(dmem_be), 32'h4);
      check("lb_wait_we", 32'(dmem_we), 0);
      check("lb_wait_stall", 32'(stall_out), 1);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hFFFF_FFFF;
      tick;
    end
    dmem_rvalid = 1'b0;
    dmem_ready  = 1'b1;
    check("lb_req_acc", 32'(dmem_req), 1);
    tick;
    dmem_ready = 1'b0;
    check("lb_resp_req", 32'(dmem_req), 0);
    check("lb_resp_stall", 32'(stall_out), 1);
    tick;
    check("lb_resp_stall2", 32'(stall_out), 1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0080_0000;
    tick;
    dmem_rvalid = 1'b0;
    check("lb_done_stall", 32'(stall_out), 0);
    check("lb_done_bubble", 32'(valid_out), 0);
    tick;
    nop;
    check("lb_data", load_data_out, 32'hFFFF_FF80);
    check("lb_valid", 32'(valid_out), 1);
    check("lb_rw", 32'(reg_write_out), 1);
    check("lb_rd", 32'(rd_addr_out), 7);

    set_op(32'h202, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b101);
    dmem_ready = 1'b1;
    tick;
    check("lhu_req", 32'(dmem_req), 1);
    check("lhu_be", 32'(dmem_be), 32'hC);
    tick;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_0000;
    tick;
    dmem_rvalid = 1'b0;
    check("lhu_bubble", 32'(valid_out), 0);
    tick;
    nop;
    check("lhu_data", load_data_out, 32'h0000_BEEF);
    check("lhu_rd", 32'(rd_addr_out), 8);
    check("lhu_valid", 32'(valid_out), 1);

    set_op(32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
    #1;
    check("mis_stall", 32'(stall_out), 0);
    check("mis_req", 32'(dmem_req), 0);
    tick;
    nop;
    check("mis_exc", 32'(misalign_exc), 1);
    check("mis_rw", 32'(reg_write_out), 0);
    check("mis_valid", 32'(valid_out), 1);
    check("mis_req2", 32'(dmem_req), 0);
    tick;
    check("mis_exc_clr", 32'(misalign_exc), 0);

    set_op(32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010);
    dmem_ready = 1'b1;
    tick;
    tick;
    dmem_ready = 1'b0;
    flush      = 1'b1;
    check("flr_resp_stall", 32'(stall_out), 1);
    tick;
    flush       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    tick;
    dmem_rvalid = 1'b0;
    check("flr_done_stall", 32'(stall_out), 0);
    tick;
    nop;
    check("flr_valid", 32'(valid_out), 0);
    check("flr_rw", 32'(reg_write_out), 0);

    set_op(32'h400, 32'hDEAD_BEEF, 5'd11, 1'b0, 1'b0, 1'b1, 3'b010);
    dmem_ready = 1'b0;
    tick;
    check("rr_req", 32'(dmem_req), 1);
    check("rr_be", 32'(dmem_be), 32'hF);
    check("rr_wdata", dmem_wdata, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("rr_req_drop", 32'(dmem_req), 0);
    check("rr_be0", 32'(dmem_be), 0);
    check("rr_valid0", 32'(valid_out), 0);
    check("rr_alu0", alu_result_out, 0);
    check("rr_pc0", pc_out, 0);
    nop;
    #3;
    rst_n = 1'b1;
    tick;
    check("rr_idle_req", 32'(dmem_req), 0);
    check("rr_idle_stall", 32'(stall_out), 0);
    check("rr_idle_valid", 32'(valid_out), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage of the 5-stage RV32I core. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. Performs loads and stores over a req/ready + rvalid data-memory handshake. Stalls the upstream pipeline until an access completes, then presents a registered, writeback-ready result.

Parameters:
ADDR_W, 32, data-memory address width (byte address)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
flush  in  1  discard current op (turn it into a bubble)
pc_in  in  32  PC from EX/MEM
alu_result_in  in  32  ALU result / effective address
rs2_data_in  in  32  store data
rd_addr_in  in  5  destination register
reg_write_in  in  1  writeback enable
mem_read_in  in  1  load op
mem_write_in  in  1  store op
wb_sel_in  in  2  writeback select (passed through)
funct3_in  in  3  access size/sign
stall_out  out  1  freeze EX/MEM and earlier stages
dmem_req  out  1  memory request valid
dmem_we  out  1  1=store
dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-aligned store data
dmem_be  out  4  byte enables
dmem_ready  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load word
pc_out  out  32  registered PC
alu_result_out  out  32  registered ALU result
load_data_out  out  32  registered extended load data
rd_addr_out  out  5  registered rd
reg_write_out  out  1  registered writeback enable
wb_sel_out  out  2  registered wb_sel
valid_out  out  1  registered: 1 = real op, 0 = bubble
misalign_exc  out  1  registered one-cycle pulse on a misaligned or illegal access

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n.
- Reset: FSM=IDLE; all outputs 0; dmem_req=0; latched request and pending-flush cleared.
- Mem op = mem_read_in | mem_write_in. If both are set, treat as a load.
- Alignment check:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Legal load funct3: 000/001/010/100/101. Legal store funct3: 000/001/010.
  - Anything else is illegal.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, non-mem op or flush: stall_out=0; output registers capture inputs at the edge (load_data_out=0); latency 1.
- IDLE, aligned mem op, no flush:
  - stall_out=1 (combinational).
  - Latch addr, byte enables, wdata, we, funct3 and addr[1:0]; go to REQ.
  - Output registers load a bubble (valid_out=0, reg_write_out=0).
- IDLE, misaligned/illegal mem op: no request; stall_out=0.
  - Capture outputs with reg_write_out=0, valid_out=1, misalign_exc=1 for one cycle.
- REQ: dmem_req=1 from latched values; stall_out=1.
  - Stay in REQ while dmem_ready=0; all request signals held stable.
  - On dmem_ready: store goes to DONE; load goes to RESP.
- RESP: dmem_req=0; stall_out=1.
  - On dmem_rvalid: extract and extend data, latch it, go to DONE.
  - An rvalid in any other state is ignored.
- DONE: stall_out=0.
  - At the edge, output registers capture the inputs plus latched load data; go to IDLE.
  - Upstream advances on the same edge.
- Store lanes:
  - SB: be=0001<<a[1:0]; wdata=byte replicated ×4.
  - SH: be=0011<<a[1:0]; wdata=half replicated ×2.
  - SW: be=1111.
- Load extraction: byte/half selected by latched a[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Flush:
  - In IDLE/DONE: the captured op becomes a bubble (valid_out=0, reg_write_out=0, misalign_exc=0).
  - In REQ/RESP: the access still completes (a store is still performed). A pending-flush bit is set and the result is written as a bubble at DONE.
- Minimum latencies, from the op first appearing:
  - Store with ready in the first REQ cycle: 3 cycles.
  - Load with rvalid the cycle after accept: 4 cycles.
- Reset mid-access: immediate return to IDLE; dmem_req drops asynchronously.

Test Plan:
- ALU op (reg_write=1, rd=5, alu=0x1234) in IDLE → next edge: alu_result_out=0x1234, rd_addr_out=5, valid_out=1; stall_out never high.
- SB addr=0x103, rs2=0xAB, ready=1 on first REQ cycle → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100; stall high 2 cycles; store retires with valid_out=1.
- LB addr=0x102, rdata=0x00800000, ready delayed 3 cycles, rvalid 2 cycles after accept → dmem_req held stable through the wait; load_data_out=0xFFFFFF80; stall held until DONE.
- LHU addr=0x202, rdata=0xBEEF0000 → load_data_out=0x0000BEEF.
- LW addr=0x101 → no dmem_req; misalign_exc pulses once; reg_write_out=0; stall_out stays 0.
- flush during RESP of LW; then rst_n low during REQ of a later op → first: valid_out=0 and reg_write_out=0 at DONE. Second: dmem_req and all outputs 0 immediately; FSM=IDLE.
